// File: rtl/data_tx_rx_pkg.sv
// Shared types and constants for the data_tx_rx Ethernet framer/listener.
`timescale 1ns/1ps
package data_tx_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PLD  = 2'd2
    } tx_state_t;

    localparam int unsigned HDR_LEN      = 14;
    localparam int unsigned MIN_PLD      = 46;

    // Header byte positions: dst MAC, source MAC, ethertype
    localparam int unsigned HDR_DST_IDX  = 0;
    localparam int unsigned HDR_SRC_IDX  = 6;
    localparam int unsigned HDR_TYPE_IDX = 12;

    // Source-address window inside a received frame
    localparam int unsigned RX_MAC_FIRST = 6;
    localparam int unsigned RX_MAC_LAST  = 11;

    // Header byte idx (0..13) of {dst, src, ethertype}, MSB first
    function automatic logic [7:0] hdr_byte(input logic [47:0] dst,
                                            input logic [47:0] src,
                                            input logic [15:0] etype,
                                            input logic [3:0]  idx);
        logic [111:0] hdr;
        hdr = {dst, src, etype} << {idx, 3'b000};
        return hdr[111:104];
    endfunction

endpackage

// File: rtl/data_tx_rx_rx_mac_learner.sv
// Listens to the RX LocalLink stream and learns the peer MAC from the
// source-address bytes of every frame long enough to contain them.
`timescale 1ns/1ps
module rx_mac_learner
    import data_tx_rx_pkg::*;
#(
    parameter logic [47:0] DEFAULT_DST_MAC = 48'hFFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_sof,
    input  logic        rx_eof,
    input  logic        rx_src_rdy,
    output logic [47:0] learned_mac
);

    logic [7:0]  pos;
    logic        in_frame;
    logic [47:0] shadow;
    logic [47:0] shadow_nxt_c;
    logic [7:0]  cur_pos_c;
    logic        accept_c;

    // A sof byte is position 0 regardless of where the previous frame stopped
    assign cur_pos_c = rx_sof ? 8'd0 : pos;
    assign accept_c  = rx_src_rdy && (rx_sof || in_frame);

    // Source-address bytes shift in MSB first; six shifts fill the shadow
    always_comb begin
        shadow_nxt_c = shadow;
        if (cur_pos_c >= 8'(RX_MAC_FIRST) && cur_pos_c <= 8'(RX_MAC_LAST)) begin
            shadow_nxt_c = {shadow[39:0], rx_data};
        end
    end

    // Position tracking and learned-MAC commit on a long-enough eof byte
    always_ff @(posedge clk) begin
        if (reset) begin
            pos         <= 8'd0;
            in_frame    <= 1'b0;
            shadow      <= 48'd0;
            learned_mac <= DEFAULT_DST_MAC;
        end else if (accept_c) begin
            shadow   <= shadow_nxt_c;
            pos      <= (cur_pos_c == 8'hFF) ? cur_pos_c : cur_pos_c + 8'd1;
            in_frame <= !rx_eof;
            if (rx_eof && cur_pos_c >= 8'(RX_MAC_LAST)) begin
                learned_mac <= shadow_nxt_c;
            end
        end
    end

endmodule

// File: rtl/data_tx_rx.sv
// Byte-wide Ethernet framer (TX) and peer-MAC listener (RX).
// Optional feature macro: DATA_TX_RX_PAD_EN zero-pads short payloads to 46 bytes.
`timescale 1ns/1ps
module data_tx_rx
    import data_tx_rx_pkg::*;
#(
    parameter logic [47:0] SRC_MAC         = 48'h000A_3501_0203,
    parameter logic [47:0] DEFAULT_DST_MAC = 48'hFFFF_FFFF_FFFF,
    parameter logic [15:0] ETHERTYPE       = 16'h88B5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_sof,
    input  logic       rx_eof,
    input  logic       rx_src_rdy,
    output logic [7:0] tx_data,
    output logic       tx_sof,
    output logic       tx_eof,
    output logic       tx_src_rdy,
    input  logic       tx_dest_rdy,
    input  logic       start_tx,
    input  logic [7:0] data_tx,
    input  logic [7:0] length_tx,
    output logic       payload,
    output logic       busy
);

    tx_state_t   state;
    logic [3:0]  hdr_idx;
    logic [8:0]  pld_cnt;
    logic [7:0]  len_q;
    logic [47:0] dst_q;
    logic [7:0]  hdr_q;
    logic [47:0] learned_mac;
    logic [8:0]  pld_total_c;
    logic        user_phase_c;

    rx_mac_learner #(
        .DEFAULT_DST_MAC (DEFAULT_DST_MAC)
    ) u_rx_mac_learner (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_sof      (rx_sof),
        .rx_eof      (rx_eof),
        .rx_src_rdy  (rx_src_rdy),
        .learned_mac (learned_mac)
    );

    // Number of payload bytes on the wire, including any zero padding
`ifdef DATA_TX_RX_PAD_EN
    assign pld_total_c = (len_q < 8'(MIN_PLD)) ? 9'(MIN_PLD) : {1'b0, len_q};
`else
    assign pld_total_c = {1'b0, len_q};
`endif

    // User bytes pass straight through; padding bytes are zero and not consumed
    assign user_phase_c = (state == PLD) && (pld_cnt < {1'b0, len_q});
    assign tx_data      = (state == PLD) ? (user_phase_c ? data_tx : 8'd0) : hdr_q;
    assign payload      = user_phase_c && tx_dest_rdy;

    // TX frame FSM: header byte register, payload counter and framing flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            tx_src_rdy <= 1'b0;
            tx_sof     <= 1'b0;
            tx_eof     <= 1'b0;
            hdr_q      <= 8'd0;
            hdr_idx    <= 4'd0;
            pld_cnt    <= 9'd0;
            len_q      <= 8'd0;
            dst_q      <= DEFAULT_DST_MAC;
        end else begin
            case (state)
                IDLE: begin
                    if (start_tx && length_tx != 8'd0) begin
                        state      <= HDR;
                        busy       <= 1'b1;
                        tx_src_rdy <= 1'b1;
                        tx_sof     <= 1'b1;
                        len_q      <= length_tx;
                        dst_q      <= learned_mac;
                        hdr_q      <= learned_mac[47:40];
                        hdr_idx    <= 4'd0;
                    end
                end
                HDR: begin
                    if (tx_dest_rdy) begin
                        tx_sof <= 1'b0;
                        if (hdr_idx == 4'(HDR_LEN - 1)) begin
                            state   <= PLD;
                            hdr_q   <= 8'd0;
                            pld_cnt <= 9'd0;
                            tx_eof  <= (pld_total_c == 9'd1);
                        end else begin
                            hdr_idx <= hdr_idx + 4'd1;
                            hdr_q   <= hdr_byte(dst_q, SRC_MAC, ETHERTYPE, hdr_idx + 4'd1);
                        end
                    end
                end
                PLD: begin
                    if (tx_dest_rdy) begin
                        if (tx_eof) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            tx_src_rdy <= 1'b0;
                            tx_eof     <= 1'b0;
                        end else begin
                            pld_cnt <= pld_cnt + 9'd1;
                            tx_eof  <= (pld_cnt + 9'd2 == pld_total_c);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_tx_rx.sv
// Self-checking bench for data_tx_rx: frame-level reference model checked
// every cycle, plus literal expectations on captured TX frames.
`timescale 1ns/1ps
module tb_data_tx_rx;

    localparam logic [47:0] SRC = 48'h000A35010203;
    localparam logic [47:0] DEF = 48'hFFFFFFFFFFFF;
    localparam logic [15:0] ET  = 16'h88B5;
`ifdef DATA_TX_RX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_sof = 1'b0, rx_eof = 1'b0, rx_src_rdy = 1'b0;
    logic       tx_dest_rdy = 1'b0, start_tx = 1'b0;
    logic [7:0] data_tx = 8'd0, length_tx = 8'd0;
    logic [7:0] tx_data;
    logic       tx_sof, tx_eof, tx_src_rdy, payload, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_tx_rx dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_sof      (rx_sof),
        .rx_eof      (rx_eof),
        .rx_src_rdy  (rx_src_rdy),
        .tx_data     (tx_data),
        .tx_sof      (tx_sof),
        .tx_eof      (tx_eof),
        .tx_src_rdy  (tx_src_rdy),
        .tx_dest_rdy (tx_dest_rdy),
        .start_tx    (start_tx),
        .data_tx     (data_tx),
        .length_tx   (length_tx),
        .payload     (payload),
        .busy        (busy)
    );

    // Reference model: frame as a byte index, RX as a byte queue per frame
    bit          m_valid = 1'b0;
    bit          m_busy = 1'b0;
    int          m_idx = 0;
    int          m_len = 0;
    logic [47:0] m_dst = DEF;
    logic [47:0] m_learned = DEF;
    bit          r_in = 1'b0;
    byte unsigned rxq[$];

    always @(negedge clk) begin
        logic [111:0] h;
        logic [12:0]  exp_v, act_v;
        logic [7:0]   e_data;
        logic         e_sof, e_eof, e_pl;
        int           total, p;
        total  = 14 + ((PAD && m_len < 46) ? 46 : m_len);
        e_data = 8'd0; e_sof = 1'b0; e_eof = 1'b0; e_pl = 1'b0;
        if (m_busy) begin
            e_sof = (m_idx == 0);
            e_eof = (m_idx == total - 1);
            if (m_idx < 14) begin
                h = {m_dst, SRC, ET};
                e_data = h[111 - 8*m_idx -: 8];
            end else begin
                p = m_idx - 14;
                if (p < m_len) begin
                    e_data = data_tx;
                    e_pl   = tx_dest_rdy;
                end
            end
        end
        if (m_valid) begin
            exp_v = {m_busy, m_busy, e_sof, e_eof, e_pl, e_data};
            act_v = {busy, tx_src_rdy, tx_sof, tx_eof, payload, tx_data};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_model t=%0t {busy,rdy,sof,eof,payload,data} got %h expected %h",
                         $time, act_v, exp_v);
            end
        end
        if (reset) begin
            m_busy = 1'b0; m_learned = DEF; r_in = 1'b0; rxq.delete(); m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_busy) begin
                if (tx_dest_rdy) begin
                    if (m_idx == total - 1) m_busy = 1'b0;
                    else m_idx++;
                end
            end else if (start_tx && length_tx != 8'd0) begin
                m_busy = 1'b1; m_idx = 0; m_len = int'(length_tx); m_dst = m_learned;
            end
            if (rx_src_rdy) begin
                if (rx_sof) begin rxq.delete(); r_in = 1'b1; end
                if (r_in) begin
                    rxq.push_back(rx_data);
                    if (rx_eof) begin
                        r_in = 1'b0;
                        if (rxq.size() >= 12)
                            for (int i = 0; i < 6; i++) m_learned[47 - 8*i -: 8] = rxq[6 + i];
                    end
                end
            end
        end
    end

    // Transfer monitor feeding the literal frame checks
    byte unsigned txq[$];
    bit           eofq[$];
    int           pl_total = 0;
    always @(negedge clk) begin
        if (!reset && tx_src_rdy && tx_dest_rdy) begin
            txq.push_back(tx_data);
            eofq.push_back(tx_eof);
        end
        if (!reset && payload) pl_total++;
    end

    logic [7:0] rx_pat[16];
    logic [7:0] exp26[26];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start(input logic [7:0] len);
        start_tx = 1'b1; length_tx = len;
        cyc();
        start_tx = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int k = 0;
        while (busy && k < maxc) begin cyc(); k++; end
        check(name, int'(busy), 0);
    endtask

    task automatic set_mac(input logic [47:0] m);
        for (int i = 0; i < 16; i++) rx_pat[i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 6; i++) rx_pat[6 + i] = m[47 - 8*i -: 8];
    endtask

    task automatic send_rx(input int n, input bit with_sof, input bit with_eof);
        for (int i = 0; i < n; i++) begin
            rx_src_rdy = 1'b1; rx_data = rx_pat[i];
            rx_sof = with_sof && (i == 0);
            rx_eof = with_eof && (i == n - 1);
            cyc();
        end
        rx_src_rdy = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'd0;
    endtask

    task automatic check_dst(input int base, input logic [47:0] mac, input string name);
        check({name, "_len"}, (txq.size() >= base + 6) ? 1 : 0, 1);
        for (int i = 0; i < 6 && base + i < txq.size(); i++)
            check(name, int'(txq[base + i]), int'(mac[47 - 8*i -: 8]));
    endtask

    initial begin
        int base, pl0, n_eof, exp_len;

        // Reset values
        cyc(3);
        reset = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_src_rdy", int'(tx_src_rdy), 0);
        check("rst_flags", int'({tx_sof, tx_eof, payload}), 0);
        check("rst_data", int'(tx_data), 0);

        // Start while sink stalls: first header byte held
        data_tx = 8'hE0; tx_dest_rdy = 1'b0;
        base = txq.size(); pl0 = pl_total;
        pulse_start(8'h0C);
        cyc(8);
        check("stall_busy", int'(busy), 1);
        check("stall_sof", int'(tx_sof), 1);
        check("stall_data", int'(tx_data), 8'hFF);
        check("stall_payload", int'(payload), 0);

        // Release sink: 26-byte frame
        tx_dest_rdy = 1'b1;
        wait_idle(100, "frame26_timeout");
        exp26 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                  8'h00, 8'h0A, 8'h35, 8'h01, 8'h02, 8'h03, 8'h88, 8'hB5,
                  8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0,
                  8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0};
        check("frame26_len", txq.size() - base, 26);
        for (int i = 0; i < 26 && base + i < txq.size(); i++)
            check("frame26_byte", int'(txq[base + i]), int'(exp26[i]));
        n_eof = 0;
        for (int i = base; i < eofq.size(); i++) n_eof += int'(eofq[i]);
        check("frame26_eof_count", n_eof, 1);
        check("frame26_eof_last", (eofq.size() == base + 26) ? int'(eofq[base + 25]) : 0, 1);
        check("frame26_payload_cycles", pl_total - pl0, 12);

        // Learn peer MAC from a 14-byte RX frame
        cyc(2);
        set_mac(48'h021122334455);
        send_rx(14, 1'b1, 1'b1);
        cyc();
        data_tx = 8'h5A; base = txq.size();
        pulse_start(8'd1);
        wait_idle(50, "learn_timeout");
        check("learn_len", txq.size() - base, 15);
        check_dst(base, 48'h021122334455, "learn_dst");
        check("learn_user_byte", (txq.size() >= base + 15) ? int'(txq[base + 14]) : -1, 8'h5A);

        // Short RX frame (eof at position 7) must not change the MAC
        set_mac(48'h777777777777);
        send_rx(8, 1'b1, 1'b1);
        cyc();
        base = txq.size();
        pulse_start(8'd1);
        wait_idle(50, "short_timeout");
        check_dst(base, 48'h021122334455, "short_dst");

        // Throttled sink, start while busy, start with zero length
        base = txq.size();
        pulse_start(8'd3);
        for (int k = 0; k < 60; k++) begin
            tx_dest_rdy = (k % 3 != 0);
            data_tx     = 8'(k * 7);
            start_tx    = (k == 5) || (k == 50);
            length_tx   = (k == 50) ? 8'd0 : 8'd5;
            cyc();
        end
        start_tx = 1'b0; tx_dest_rdy = 1'b1;
        wait_idle(50, "throttle_timeout");
        check("throttle_len", txq.size() - base, 17);
        check("zero_len_idle", int'(busy), 0);

        // RX activity during TX: stray bytes, sof restart, then full frame
        base = txq.size();
        pulse_start(8'd30);
        set_mac(48'h0E0D0C0B0A09);
        send_rx(3, 1'b0, 1'b1);
        send_rx(9, 1'b1, 1'b0);
        send_rx(14, 1'b1, 1'b1);
        wait_idle(100, "rx_during_tx_timeout");
        check("rx_during_tx_len", txq.size() - base, 44);
        check_dst(base, 48'h021122334455, "snapshot_dst");
        cyc();
        base = txq.size();
        pulse_start(8'd1);
        wait_idle(50, "new_mac_timeout");
        check_dst(base, 48'h0E0D0C0B0A09, "new_dst");

        // Reset mid-frame aborts without eof and restores default MAC
        base = txq.size();
        pulse_start(8'd10);
        cyc(5);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_src_rdy", int'(tx_src_rdy), 0);
        n_eof = 0;
        for (int i = base; i < eofq.size(); i++) n_eof += int'(eofq[i]);
        check("abort_no_eof", n_eof, 0);
        base = txq.size();
        pulse_start(8'd1);
        wait_idle(50, "post_reset_timeout");
        check_dst(base, DEF, "post_reset_dst");

        // Two-byte payload: 60-byte padded frame or 16-byte plain frame
        cyc();
        data_tx = 8'hC3; base = txq.size(); pl0 = pl_total;
        pulse_start(8'd2);
        wait_idle(200, "pad_timeout");
        exp_len = PAD ? 60 : 16;
        check("pad_len", txq.size() - base, exp_len);
        for (int i = 14; i < exp_len && base + i < txq.size(); i++)
            check("pad_byte", int'(txq[base + i]), (i < 16) ? 8'hC3 : 0);
        check("pad_eof_last", (eofq.size() == base + exp_len) ? int'(eofq[base + exp_len - 1]) : 0, 1);
        check("pad_payload_cycles", pl_total - pl0, 2);

        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
